// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the ROM address, and buffers {pc, inst}
// pairs in a small FIFO. Redirects flush everything; rst acts as a redirect to RESET_PC.
module fetch_unit #(
    parameter int unsigned     WORD     = 32,
    parameter int unsigned     ADDR     = 32,
    parameter logic [ADDR-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic [ADDR-1:0] rom_addr,
    input  logic [WORD-1:0] rom_dout,
    input  logic            redirect,
    input  logic [ADDR-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ADDR-1:0] out_pc,
    output logic [WORD-1:0] out_inst
);
    localparam int unsigned   PW      = $clog2(DEPTH);
    localparam logic [PW+1:0] DEPTH_C = (PW+2)'(DEPTH);

    logic [ADDR-1:0] r_fetch_pc;
    logic            r_req_valid;
    logic [ADDR-1:0] r_req_pc;
    logic [PW:0]     r_count;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [ADDR-1:0] r_mem_pc   [DEPTH];
    logic [WORD-1:0] r_mem_inst [DEPTH];

    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [PW+1:0]   w_credit_used;
    logic [PW+1:0]   w_credit_avail;
    logic [PW:0]     w_count_next;

    assign rom_addr  = r_fetch_pc;
    assign out_valid = (r_count != '0);
    assign out_pc    = r_mem_pc[r_rd_ptr];
    assign out_inst  = r_mem_inst[r_rd_ptr];

    assign w_pop  = out_valid && out_ready;
    assign w_push = r_req_valid;

    // An issue is allowed only if its data is guaranteed a FIFO slot on arrival.
    assign w_credit_used  = {1'b0, r_count} + {{(PW+1){1'b0}}, r_req_valid};
    assign w_credit_avail = DEPTH_C + {{(PW+1){1'b0}}, w_pop};
    assign w_issue        = !rst && !redirect && (w_credit_used < w_credit_avail);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc  <= RESET_PC;
            r_req_valid <= 1'b0;
            r_req_pc    <= '0;
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem_pc[i]   <= '0;
                r_mem_inst[i] <= '0;
            end
        end else if (redirect) begin
            // In-flight word is squashed and any same-cycle pop is discarded.
            r_fetch_pc  <= redirect_pc;
            r_req_valid <= 1'b0;
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
        end else begin
            if (w_issue) begin
                r_req_valid <= 1'b1;
                r_req_pc    <= r_fetch_pc;
                r_fetch_pc  <= r_fetch_pc + ADDR'(4);
            end else begin
                r_req_valid <= 1'b0;
            end
            if (w_push) begin
                r_mem_pc[r_wr_ptr]   <= r_req_pc;
                r_mem_inst[r_wr_ptr] <= rom_dout;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: ROM model returns 0x1000 + addr/4 one cycle after the address;
// a scoreboard queue holds the expected {pc, inst} stream from each restart point.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] rom_addr;
    logic [31:0] rom_dout;
    logic [31:0] redirect_pc;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    logic [63:0] sb[$];
    logic [63:0] sb_exp;

    fetch_unit #(
        .WORD(32), .ADDR(32), .RESET_PC(RST_PC), .DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return 32'h0000_1000 + (a >> 2);
    endfunction

    always_ff @(posedge clk) rom_dout <= rom_fn(rom_addr);

    // Scoreboard: every accepted output must match the next expected pair.
    always @(negedge clk) begin
        if (rst === 1'b0 && redirect === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            total++;
            pops++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow got pc=%h inst=%h want=none", out_pc, out_inst);
            end else begin
                sb_exp = sb.pop_front();
                if ({out_pc, out_inst} !== sb_exp) begin
                    bad++;
                    $display("FAIL sb_order got pc=%h inst=%h want pc=%h inst=%h",
                             out_pc, out_inst, sb_exp[63:32], sb_exp[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic [31:0] start);
        logic [31:0] a;
        a = start;
        sb.delete();
        for (int i = 0; i < 1200; i++) begin
            sb.push_back({a, rom_fn(a)});
            a = a + 32'd4;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        tick(); tick(); tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", out_pc); end
        total++; if (out_inst !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h want=0", out_inst); end
        total++; if (rom_addr !== RST_PC) begin bad++; $display("FAIL rst_addr got=%h want=%h", rom_addr, RST_PC); end
        restart(RST_PC);
        rst = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_lat1 got=%b want=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_lat2 got=%b want=1", out_valid); end
        total++; if (out_pc !== RST_PC) begin bad++; $display("FAIL rst_first_pc got=%h want=%h", out_pc, RST_PC); end
        total++; if (out_inst !== 32'h1040) begin bad++; $display("FAIL rst_first_inst got=%h want=1040", out_inst); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) begin
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_gap cyc=%0d got=%b want=1", i, out_valid); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] h_pc;
        logic [31:0] h_inst;
        logic [31:0] h_addr;
        h_pc   = sb[0][63:32];
        h_inst = sb[0][31:0];
        h_addr = h_pc + 32'd8;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid cyc=%0d got=%b want=1", i, out_valid); end
            total++; if (out_pc !== h_pc) begin bad++; $display("FAIL stall_pc cyc=%0d got=%h want=%h", i, out_pc, h_pc); end
            total++; if (out_inst !== h_inst) begin bad++; $display("FAIL stall_inst cyc=%0d got=%h want=%h", i, out_inst, h_inst); end
            total++; if (rom_addr !== h_addr) begin bad++; $display("FAIL stall_issue cyc=%0d got=%h want=%h", i, rom_addr, h_addr); end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL resume_gap cyc=%0d got=%b want=1", i, out_valid); end
            tick();
        end
    endtask

    task automatic test_redirect_full();
        out_ready = 1'b0;
        tick(); tick();
        redirect = 1'b1; redirect_pc = 32'h40; restart(32'h40);
        tick();
        redirect = 1'b0; out_ready = 1'b1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rdf_flush got=%b want=0", out_valid); end
        total++; if (rom_addr !== 32'h40) begin bad++; $display("FAIL rdf_addr got=%h want=40", rom_addr); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rdf_dead got=%b want=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rdf_lat got=%b want=1", out_valid); end
        total++; if (out_pc !== 32'h40) begin bad++; $display("FAIL rdf_pc got=%h want=40", out_pc); end
        total++; if (out_inst !== 32'h1010) begin bad++; $display("FAIL rdf_inst got=%h want=1010", out_inst); end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_back_to_back();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_pre got=%b want=1", out_valid); end
        redirect = 1'b1; redirect_pc = 32'h200; restart(32'h200);
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_popdrop got=%b want=0", out_valid); end
        redirect_pc = 32'h300; restart(32'h300);
        tick();
        redirect_pc = 32'h0; restart(32'h0);
        tick();
        redirect = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_v1 got=%b want=0", out_valid); end
        total++; if (rom_addr !== 32'h0) begin bad++; $display("FAIL b2b_addr got=%h want=0", rom_addr); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_v2 got=%b want=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_v3 got=%b want=1", out_valid); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL b2b_pc got=%h want=0", out_pc); end
        total++; if (out_inst !== 32'h1000) begin bad++; $display("FAIL b2b_inst got=%h want=1000", out_inst); end
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_random();
        int start_pops;
        logic [31:0] tgt;
        start_pops = pops;
        for (int i = 0; i < 1000; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 63) == 0) begin
                tgt = $urandom & 32'hFFFF_FFFC;
                redirect = 1'b1; redirect_pc = tgt; restart(tgt);
            end else begin
                redirect = 1'b0;
            end
            tick();
        end
        redirect = 1'b0; out_ready = 1'b1;
        total++;
        if (pops - start_pops < 200) begin
            bad++; $display("FAIL rand_progress got=%0d want>=200", pops - start_pops);
        end
    endtask

    task automatic test_reset_mid();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF4; restart(32'hFFFF_FFF4);
        tick();
        redirect = 1'b0;
        tick(); tick();
        total++; if (rom_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL rmid_addr got=%h want=fffffffc", rom_addr); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre got=%b want=1", out_valid); end
        rst = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", out_valid); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL rmid_pc got=%h want=0", out_pc); end
        total++; if (out_inst !== 32'h0) begin bad++; $display("FAIL rmid_inst got=%h want=0", out_inst); end
        total++; if (rom_addr !== RST_PC) begin bad++; $display("FAIL rmid_rstaddr got=%h want=%h", rom_addr, RST_PC); end
        restart(RST_PC);
        rst = 1'b0;
        tick(); tick();
        total++; if (out_pc !== RST_PC || out_valid !== 1'b1) begin
            bad++; $display("FAIL rmid_restart got pc=%h v=%b want pc=%h v=1", out_pc, out_valid, RST_PC);
        end
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; restart(32'hFFFF_FFFC);
        tick();
        redirect = 1'b0;
        tick(); tick();
        total++; if (out_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_last got=%h want=fffffffc", out_pc); end
        tick();
        total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h want=0", out_pc); end
        total++; if (out_inst !== 32'h1000) begin bad++; $display("FAIL wrap_inst got=%h want=1000", out_inst); end
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
